// File: rtl/hex_pkg.sv
// Shared segment constants, controller state encoding and an elaboration-time
// power-of-ten helper for the hex/decimal display controller.
package hex_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < n; i++) r = r * 64'd10;
      return r;
   endfunction

endpackage

// File: rtl/hex_display_ctrl_hexdriver.sv
// 4-bit nibble to active-low 7-segment pattern, segment order {g,f,e,d,c,b,a}.
module HexDriver (
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   always_comb begin
      unique case (digit)
         4'h0: seg = 7'b1000000;
         4'h1: seg = 7'b1111001;
         4'h2: seg = 7'b0100100;
         4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;
         4'h5: seg = 7'b0010010;
         4'h6: seg = 7'b0000010;
         4'h7: seg = 7'b1111000;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0010000;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b0000011;
         4'hC: seg = 7'b1000110;
         4'hD: seg = 7'b0100001;
         4'hE: seg = 7'b0000110;
         default: seg = 7'b0001110;
      endcase
   end

endmodule

// File: rtl/hex_display_ctrl.sv
// Captures a value, optionally converts it to BCD by double-dabble, commits the
// digit vector and drives NUM_DIGITS segment displays with blanking and blink.
module hex_display_ctrl
   import hex_pkg::*;
#(
   parameter int NUM_DIGITS = 6,
   parameter int DATA_W     = 20,
   parameter int BLINK_DIV  = 25_000_000
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic                    load,
   input  logic [DATA_W-1:0]       value,
   input  logic                    dec_mode,
   input  logic                    blank_lz,
   input  logic                    blink_en,
   output logic                    busy,
   output logic                    overflow,
   output logic [7*NUM_DIGITS-1:0] hex_out
);

   localparam int DW4 = 4 * NUM_DIGITS;
   localparam int CW  = $clog2(DATA_W + 1);
   localparam int BW  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [63:0] DEC_MAX = pow10(NUM_DIGITS) - 64'd1;

   state_t                       state;
   logic [DATA_W-1:0]            cap_val, sh;
   logic                         cap_dec;
   logic [CW-1:0]                bit_cnt;
   logic [NUM_DIGITS-1:0][3:0]   bcd, bcd_adj, bcd_nxt, dig_src, dig;
   logic [NUM_DIGITS-1:0]        lz_src, lz_mask;
   logic [NUM_DIGITS-1:0][6:0]   seg_raw;
   logic                         ovf_src, live, phase, seen;
   logic [BW-1:0]                blink_cnt;
   logic [63:0]                  val64;

   // Only the low NUM_DIGITS BCD digits are kept: carries only move upward,
   // so truncation never corrupts them and overflow is decided separately.
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (bcd[i] >= 4'd5) bcd_adj[i] = bcd[i] + 4'd3;
      bcd_nxt = DW4'({bcd_adj, sh[DATA_W-1]});
   end

   always_comb begin
      val64   = 64'(cap_val);
      dig_src = cap_dec ? bcd : val64[DW4-1:0];
      ovf_src = cap_dec ? (val64 > DEC_MAX) : ((val64 >> DW4) != 64'd0);
      seen    = 1'b0;
      lz_src  = '0;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         if (dig_src[i] != 4'd0) seen = 1'b1;
         lz_src[i] = !seen;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state    <= IDLE;
         busy     <= 1'b0;
         cap_val  <= '0;
         sh       <= '0;
         cap_dec  <= 1'b0;
         bit_cnt  <= '0;
         bcd      <= '0;
         dig      <= '0;
         lz_mask  <= '1;
         overflow <= 1'b0;
         live     <= 1'b0;
      end else begin
         case (state)
            IDLE: if (load) begin
               cap_val <= value;
               sh      <= value;
               cap_dec <= dec_mode;
               bcd     <= '0;
               bit_cnt <= '0;
               busy    <= 1'b1;
               state   <= dec_mode ? CONVERT : COMMIT;
            end
            CONVERT: begin
               bcd     <= bcd_nxt;
               sh      <= sh << 1;
               bit_cnt <= bit_cnt + CW'(1);
               if (bit_cnt == CW'(DATA_W - 1)) state <= COMMIT;
            end
            COMMIT: begin
               dig      <= dig_src;
               overflow <= ovf_src;
               lz_mask  <= lz_src;
               live     <= 1'b1;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         blink_cnt <= '0;
         phase     <= 1'b1;
      end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
         blink_cnt <= '0;
         phase     <= ~phase;
      end else begin
         blink_cnt <= blink_cnt + BW'(1);
      end
   end

   // Blink and "nothing committed yet" beat dashes; dashes beat zero blanking.
   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
      HexDriver u_drv (
         .digit (dig[g]),
         .seg   (seg_raw[g])
      );
      assign hex_out[7*g +: 7] = ((blink_en && !phase) || !live) ? SEG_BLANK :
                                 overflow                        ? SEG_DASH  :
                                 (blank_lz && lz_mask[g])        ? SEG_BLANK :
                                                                   seg_raw[g];
   end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench: stimulus pushes hand-computed results, a monitor checks each
// completion (busy falling) against the queue.
module tb_hex_display_ctrl;

   localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                          S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                          S6 = 7'b0000010, S9 = 7'b0010000, SA = 7'b0001000,
                          SB = 7'b0000011, BL = 7'b1111111, DA = 7'b0111111;
   localparam logic [41:0] ALLBL = {6{BL}};

   typedef struct {
      logic [41:0] hex;
      logic        ovf;
      int          blen;
   } exp_t;

   logic        Clk, Reset, load, dec_mode, blank_lz, blink_en, busy, overflow;
   logic [19:0] value;
   logic [41:0] hex_out;

   exp_t q[$];
   int   n_vec = 0, n_bad = 0;
   logic abort_exp = 1'b0;

   hex_display_ctrl #(.NUM_DIGITS(6), .DATA_W(20), .BLINK_DIV(4)) dut (
      .Clk(Clk), .Reset(Reset), .load(load), .value(value), .dec_mode(dec_mode),
      .blank_lz(blank_lz), .blink_en(blink_en), .busy(busy), .overflow(overflow),
      .hex_out(hex_out)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic logic [41:0] d6(input logic [6:0] a5, a4, a3, a2, a1, a0);
      return {a5, a4, a3, a2, a1, a0};
   endfunction

   task automatic chk(input string nm, input logic [41:0] act, input logic [41:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 40 && busy; i++) @(negedge Clk);
      chk("idle_timeout", {41'd0, busy}, 42'd0);
      repeat (2) @(negedge Clk);
   endtask

   task automatic do_load(input logic [19:0] v, input logic dm, input logic [41:0] eh,
                          input logic eo, input int bl);
      q.push_back('{eh, eo, bl});
      load = 1'b1; value = v; dec_mode = dm;
      @(negedge Clk);
      load = 1'b0;
      wait_idle();
   endtask

   // Monitor: one check set per completion
   initial begin
      logic prev;
      int   blen;
      exp_t e;
      prev = 1'b0;
      blen = 0;
      forever begin
         @(posedge Clk); #1;
         if (busy === 1'b1) blen++;
         else if (prev) begin
            if (abort_exp) abort_exp = 1'b0;
            else if (q.size() == 0) chk("unexpected_done", 42'd1, 42'd0);
            else begin
               e = q.pop_front();
               chk("hex_out", hex_out, e.hex);
               chk("overflow", {41'd0, overflow}, {41'd0, e.ovf});
               chk("busy_len", 42'(blen), 42'(e.blen));
            end
            blen = 0;
         end
         prev = (busy === 1'b1);
      end
   end

   initial begin
      logic [41:0] e12345;
      e12345 = d6(S0, S1, S2, S3, S4, S5);
      Reset = 1'b1; load = 1'b1; value = 20'h12345; dec_mode = 1'b0;
      blank_lz = 1'b0; blink_en = 1'b0;
      @(negedge Clk);
      // reset wins over load; reset state blank
      chk("rst_busy", {41'd0, busy}, 42'd0);
      chk("rst_ovf", {41'd0, overflow}, 42'd0);
      chk("rst_hex", hex_out, ALLBL);

      // blink phase is known relative to the reset edge R
      Reset = 1'b0;
      q.push_back('{e12345, 1'b0, 1});
      @(negedge Clk);
      load = 1'b0;
      @(negedge Clk);
      blink_en = 1'b1;
      for (int k = 2; k < 12; k++) begin
         chk("blink", hex_out, (((k / 4) % 2) == 0) ? e12345 : ALLBL);
         @(negedge Clk);
      end
      blink_en = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1 chk("steady", hex_out, e12345);
         @(negedge Clk);
      end

      // hex load held into COMMIT: second value ignored
      blank_lz = 1'b1;
      q.push_back('{d6(BL, BL, BL, BL, SA, SB), 1'b0, 1});
      load = 1'b1; value = 20'h000AB; dec_mode = 1'b0;
      @(negedge Clk);
      value = 20'h12345;
      @(negedge Clk);
      load = 1'b0;
      wait_idle();
      blank_lz = 1'b0;
      #1 chk("live_nolz", hex_out, d6(S0, S0, S0, S0, SA, SB));
      blank_lz = 1'b1;
      #1 chk("live_lz", hex_out, d6(BL, BL, BL, BL, SA, SB));

      blank_lz = 1'b0;
      do_load(20'd123456, 1'b1, d6(S1, S2, S3, S4, S5, S6), 1'b0, 21);
      do_load(20'd999999, 1'b1, {6{S9}}, 1'b0, 21);
      blank_lz = 1'b1;
      do_load(20'd1000000, 1'b1, {6{DA}}, 1'b1, 21);
      do_load(20'd0, 1'b1, d6(BL, BL, BL, BL, BL, S0), 1'b0, 21);

      // load during CONVERT is ignored
      q.push_back('{d6(BL, BL, BL, BL, BL, S5), 1'b0, 21});
      load = 1'b1; value = 20'd5; dec_mode = 1'b1;
      @(negedge Clk);
      load = 1'b0;
      repeat (3) @(negedge Clk);
      load = 1'b1; value = 20'd99;
      @(negedge Clk);
      load = 1'b0;
      wait_idle();

      // reset mid-conversion
      load = 1'b1; value = 20'd123456; dec_mode = 1'b1;
      @(negedge Clk);
      load = 1'b0;
      repeat (9) @(negedge Clk);
      chk("abort_pre_busy", {41'd0, busy}, 42'd1);
      abort_exp = 1'b1;
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      chk("abort_busy", {41'd0, busy}, 42'd0);
      chk("abort_ovf", {41'd0, overflow}, 42'd0);
      chk("abort_hex", hex_out, ALLBL);
      repeat (25) @(negedge Clk);
      chk("abort_nocommit", hex_out, ALLBL);
      chk("queue_empty", 42'(q.size()), 42'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
